// File: rtl/fdtd_pkg.sv
// Shared widths, types and the round-half-up helper for the FDTD leapfrog update core.
package fdtd_pkg;

  localparam int FDTD_DATA_W  = 32;
  localparam int FDTD_CUT_LT  = 51;
  localparam int FDTD_CUT_RT  = 21;
  localparam int FDTD_ACC_MAX = 128;

  typedef logic signed [FDTD_DATA_W-1:0]  fdtd_word_t;
  typedef logic signed [FDTD_ACC_MAX-1:0] fdtd_acc_t;

  // Adds half an output LSB so the later truncation rounds toward +inf on ties.
  function automatic fdtd_acc_t fdtd_cut_round(input fdtd_acc_t sum, input int cut_rt);
    fdtd_acc_t half;
    half = fdtd_acc_t'(1) << (cut_rt - 1);
    return sum + half;
  endfunction

endpackage

// File: rtl/fdtd_update_lane.sv
// One lane of the FDTD update: S1 diff, S2 products, S3 sum, S4 round/cut, plus neighbour reg.
// Saturation on overflow is enabled by defining FDTD_UPDATE_SAT_EN.
module fdtd_update_lane
  import fdtd_pkg::*;
#(
  parameter int DATA_W = FDTD_DATA_W,
  parameter int CUT_LT = FDTD_CUT_LT,
  parameter int CUT_RT = FDTD_CUT_RT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              adv_i,
  input  logic              valid_i,
  input  logic              first_i,
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] curl_i,
  input  logic [DATA_W-1:0] ca_i,
  input  logic [DATA_W-1:0] cb_i,
  output logic [DATA_W-1:0] new_o,
  output logic              ovf_o
);

  localparam int PW = 2 * DATA_W + 1;
  localparam int AW = 2 * DATA_W + 2;

  logic        [DATA_W-1:0] prev_q, prev_d, prev_used;
  logic signed [DATA_W-1:0] s1_old_q, s1_old_d, s1_ca_q, s1_ca_d, s1_cb_q, s1_cb_d;
  logic signed [DATA_W:0]   s1_diff_q, s1_diff_d;
  logic signed [PW-1:0]     s2_pa_q, s2_pa_d, s2_pb_q, s2_pb_d;
  logic signed [AW-1:0]     s3_sum_q, s3_sum_d;
  logic        [DATA_W-1:0] new_q, new_d;
  logic                     ovf_q, ovf_d;

  fdtd_acc_t                r_full;
  logic [AW-1:0]            r;
  logic [AW-2-CUT_LT:0]     hi;
  logic [DATA_W-1:0]        cut;
  logic                     ovf;
  logic                     unused_bits;

  always_comb begin
    prev_d    = prev_q;
    s1_old_d  = s1_old_q;
    s1_ca_d   = s1_ca_q;
    s1_cb_d   = s1_cb_q;
    s1_diff_d = s1_diff_q;
    s2_pa_d   = s2_pa_q;
    s2_pb_d   = s2_pb_q;
    s3_sum_d  = s3_sum_q;
    new_d     = new_q;
    ovf_d     = ovf_q;

    prev_used = first_i ? '0 : prev_q;
    r_full    = fdtd_cut_round(fdtd_acc_t'(s3_sum_q), CUT_RT);
    r         = r_full[AW-1:0];
    hi        = r[AW-1:CUT_LT+1];
    ovf       = (|hi) && !(&hi);
    cut       = {r[AW-1], r[CUT_LT:CUT_RT]};

    // Neighbour tracks only accepted beats so bubbles and stalls leave it alone.
    if (valid_i && adv_i) prev_d = curl_i;

    if (adv_i) begin
      s1_old_d  = old_i;
      s1_ca_d   = ca_i;
      s1_cb_d   = cb_i;
      s1_diff_d = {curl_i[DATA_W-1], curl_i} - {prev_used[DATA_W-1], prev_used};
      s2_pa_d   = PW'(s1_ca_q) * PW'(s1_old_q);
      s2_pb_d   = PW'(s1_cb_q) * PW'(s1_diff_q);
      s3_sum_d  = AW'(s2_pa_q) + AW'(s2_pb_q);
`ifdef FDTD_UPDATE_SAT_EN
      if (ovf) begin
        new_d = r[AW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        new_d = cut;
      end
      ovf_d = ovf;
`else
      new_d = cut;
      ovf_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= '0;
      s1_old_q  <= '0;
      s1_ca_q   <= '0;
      s1_cb_q   <= '0;
      s1_diff_q <= '0;
      s2_pa_q   <= '0;
      s2_pb_q   <= '0;
      s3_sum_q  <= '0;
      new_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      s1_old_q  <= s1_old_d;
      s1_ca_q   <= s1_ca_d;
      s1_cb_q   <= s1_cb_d;
      s1_diff_q <= s1_diff_d;
      s2_pa_q   <= s2_pa_d;
      s2_pb_q   <= s2_pb_d;
      s3_sum_q  <= s3_sum_d;
      new_q     <= new_d;
      ovf_q     <= ovf_d;
    end
  end

  assign unused_bits = ^{r_full, ovf};
  assign new_o       = new_q;
  assign ovf_o       = ovf_q;

endmodule

// File: rtl/fdtd_update_core.sv
// Pipelined FDTD update core: valid/ready handshake, stage valids, LANES parallel lanes.
// Define FDTD_UPDATE_SAT_EN to clamp overflowing lanes and report ovf_o.
module fdtd_update_core
  import fdtd_pkg::*;
#(
  parameter int DATA_W = FDTD_DATA_W,
  parameter int LANES  = 1,
  parameter int CUT_LT = FDTD_CUT_LT,
  parameter int CUT_RT = FDTD_CUT_RT
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    first_i,
  input  logic [LANES*DATA_W-1:0] old_i,
  input  logic [LANES*DATA_W-1:0] curl_i,
  input  logic [LANES*DATA_W-1:0] ca_i,
  input  logic [LANES*DATA_W-1:0] cb_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [LANES*DATA_W-1:0] new_o,
  output logic                    ovf_o
);

  if (CUT_LT - CUT_RT + 2 != DATA_W) begin : g_err_cut_width
    $error("fdtd_update_core: CUT_LT-CUT_RT+2 must equal DATA_W");
  end
  if (CUT_LT >= 2 * DATA_W) begin : g_err_cut_lt
    $error("fdtd_update_core: CUT_LT must be below 2*DATA_W");
  end
  if (2 * DATA_W + 2 > FDTD_ACC_MAX || CUT_RT < 1) begin : g_err_acc
    $error("fdtd_update_core: DATA_W too wide for accumulator or CUT_RT < 1");
  end

  logic [3:0]       v_q, v_d;
  logic             adv;
  logic [LANES-1:0] lane_ovf;

  // Whole pipe advances together; a full output stage blocks only when downstream stalls.
  assign adv     = ready_i | ~v_q[3];
  assign ready_o = adv;
  assign valid_o = v_q[3];

  always_comb begin
    v_d = v_q;
    if (adv) v_d = {v_q[2:0], valid_i};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) v_q <= '0;
    else        v_q <= v_d;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fdtd_update_lane #(
      .DATA_W(DATA_W),
      .CUT_LT(CUT_LT),
      .CUT_RT(CUT_RT)
    ) u_lane (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .adv_i  (adv),
      .valid_i(valid_i),
      .first_i(first_i),
      .old_i  (old_i[g*DATA_W +: DATA_W]),
      .curl_i (curl_i[g*DATA_W +: DATA_W]),
      .ca_i   (ca_i[g*DATA_W +: DATA_W]),
      .cb_i   (cb_i[g*DATA_W +: DATA_W]),
      .new_o  (new_o[g*DATA_W +: DATA_W]),
      .ovf_o  (lane_ovf[g])
    );
  end

`ifdef FDTD_UPDATE_SAT_EN
  assign ovf_o = |lane_ovf;
`else
  logic unused_ovf;
  assign unused_ovf = ^lane_ovf;
  assign ovf_o      = 1'b0;
`endif

endmodule
